// File: rtl/uart_pkg.sv
// uart_pkg: FSM states, parity modes and data-width codes shared by the configurable UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [1:0] DATA_BITS_5 = 2'b00;
    localparam logic [1:0] DATA_BITS_6 = 2'b01;
    localparam logic [1:0] DATA_BITS_7 = 2'b10;
    localparam logic [1:0] DATA_BITS_8 = 2'b11;

    // Index of the final data bit: code 00 sends bits 0..4, code 11 sends bits 0..7.
    function automatic logic [2:0] last_data_idx(input logic [1:0] code);
        return {1'b0, code} + 3'd4;
    endfunction

    // Code 11 is treated as no parity, like 00.
    function automatic logic parity_on(input logic [1:0] mode);
        return mode == PAR_EVEN || mode == PAR_ODD;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: power-of-two FIFO with sticky overflow; a push into a full FIFO succeeds only alongside a pop.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = count == (AW+1)'(DEPTH);
    assign empty    = count == '0;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!sync_reset && do_push)
            mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(do_push);
            rd_ptr   <= rd_ptr + AW'(do_pop);
            count    <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            overflow <= overflow | (push && !do_push);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: FIFO-fed UART transmitter with per-frame latched data width, parity and stop-bit configuration.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH       = 4,
    parameter int BAUD_PERIOD_BITS = 16
) (
    input  logic                        clk,
    input  logic                        sync_reset,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    input  logic [BAUD_PERIOD_BITS-1:0] baud_rate_period_m1,
    input  logic [1:0]                  cfg_data_bits,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    output logic                        wr_overflow,
    output logic                        tx_active,
    output logic                        tx_done,
    output logic                        TXD
);

    state_t                      state;
    logic [BAUD_PERIOD_BITS-1:0] cnt;
    logic [2:0]                  bit_idx;
    logic [7:0]                  shreg;
    logic                        par_acc;
    logic [1:0]                  lat_bits;
    logic [1:0]                  lat_par;
    logic                        lat_stop2;
    logic                        stop_idx;
    logic [7:0]                  fifo_data;
    logic                        bit_end;
    logic                        frame_end;
    logic                        pop;

    assign bit_end   = cnt == baud_rate_period_m1;
    assign frame_end = state == STOP && bit_end && (!lat_stop2 || stop_idx);
    assign pop       = !fifo_empty && (state == IDLE || frame_end);

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk       (clk),
        .sync_reset(sync_reset),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (wr_overflow)
    );

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            lat_bits  <= '0;
            lat_par   <= '0;
            lat_stop2 <= 1'b0;
            stop_idx  <= 1'b0;
            TXD       <= 1'b1;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= frame_end;
            cnt     <= (state == IDLE || bit_end) ? '0 : cnt + BAUD_PERIOD_BITS'(1);
            // A pop starts the next frame, either from IDLE or straight out of the last stop period.
            if (pop) begin
                state     <= START;
                TXD       <= 1'b0;
                tx_active <= 1'b1;
                shreg     <= fifo_data;
                lat_bits  <= cfg_data_bits;
                lat_par   <= cfg_parity;
                lat_stop2 <= cfg_stop2;
                bit_idx   <= '0;
                stop_idx  <= 1'b0;
                par_acc   <= 1'b0;
            end else if (bit_end) begin
                case (state)
                    START: begin
                        state   <= DATA;
                        TXD     <= shreg[0];
                        par_acc <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                    DATA: begin
                        if (bit_idx == last_data_idx(lat_bits)) begin
                            state <= parity_on(lat_par) ? PARITY : STOP;
                            TXD   <= parity_on(lat_par) ? par_acc ^ (lat_par == PAR_ODD) : 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            TXD     <= shreg[0];
                            par_acc <= par_acc ^ shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                        TXD   <= 1'b1;
                    end
                    STOP: begin
                        if (frame_end) begin
                            state     <= IDLE;
                            tx_active <= 1'b0;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
